pattern_counter: RTL

PATTERN_COUNTER -- requirements
Module: pattern_counter

---
 rtl/pattern_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/pattern_counter.sv
// Multi-mode pattern counter stepped by a prescaler tick or a manual STEP edge.
// Optional Gray-code output is enabled by defining PATTERN_COUNTER_GRAY_EN.
module pattern_counter #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned DIV_BITS = 23,
  parameter logic [WIDTH-1:0] PAT_A = WIDTH'(10'h2AA),
  parameter logic [WIDTH-1:0] PAT_B = WIDTH'(10'h155)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             alt_sel,
  input  logic             step,
  input  logic [2:0]       mode,
  input  logic             clr,
  input  logic             load_a,
  input  logic             load_b,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             tick,
  output logic [1:0]       act
);

  logic [DIV_BITS-1:0] presc;
  logic                step_d;
  logic [1:0]          act_cnt;
  logic                step_evt;
  logic                wrap_nxt;
  logic [WIDTH-1:0]    step_val;
  logic [WIDTH-1:0]    next_cnt;

  assign tick = &presc;
  // Outputs sink current, so the indicator is inverted and bit-swapped.
  assign act  = {~act_cnt[0], ~act_cnt[1]};

  always_comb begin
    step_evt = en & (alt_sel ? (step & ~step_d) : tick);
    step_val = cnt;
    case (mode)
      3'd0:    step_val = cnt + WIDTH'(1);
      3'd1:    step_val = cnt - WIDTH'(1);
      3'd2:    step_val = cnt << 1;
      3'd3:    step_val = cnt >> 1;
      3'd4:    step_val = {cnt[WIDTH-2:0], cnt[WIDTH-1]};
      3'd5:    step_val = {cnt[0], cnt[WIDTH-1:1]};
      default: step_val = cnt;
    endcase

    wrap_nxt = 1'b0;
    if (clr)
      next_cnt = '0;
    else if (load_a)
      next_cnt = PAT_A;
    else if (load_b)
      next_cnt = PAT_B;
    else if (step_evt) begin
      next_cnt = step_val;
      wrap_nxt = ((mode == 3'd0) && (&cnt)) || ((mode == 3'd1) && (cnt == '0));
    end else
      next_cnt = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      step_d  <= 1'b0;
      act_cnt <= 2'd0;
      cnt     <= '0;
      wrap    <= 1'b0;
    end else begin
      presc   <= presc + DIV_BITS'(1);
      step_d  <= step;
      if (tick)
        act_cnt <= act_cnt + 2'd1;
      cnt     <= next_cnt;
      wrap    <= wrap_nxt;
    end
  end

`ifdef PATTERN_COUNTER_GRAY_EN
  // Registered from next_cnt so gray always matches the current cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gray <= '0;
    else
      gray <= next_cnt ^ (next_cnt >> 1);
  end
`else
  assign gray = '0;
`endif

endmodule
